// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection and branch squash; 1-cycle capture latency.
// A load-use hazard holds PC and IF/ID for one cycle and injects a bubble; an EX flush always wins over the stall.
module id_ex_hazard_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [6:0]             id_Opcode,
    input  logic                   id_ALUSrc,
    input  logic                   id_MemtoReg,
    input  logic                   id_RegWrite,
    input  logic                   id_MemRead,
    input  logic                   id_MemWrite,
    input  logic [1:0]             id_ALUOp,
    input  logic                   id_Branch,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic [4:0]             id_rd,
    input  logic [2:0]             id_funct3,
    input  logic [6:0]             id_funct7,
    input  logic                   ex_flush,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ex_ALUSrc,
    output logic                   ex_MemtoReg,
    output logic                   ex_RegWrite,
    output logic                   ex_MemRead,
    output logic                   ex_MemWrite,
    output logic                   ex_Branch,
    output logic [1:0]             ex_ALUOp,
    output logic [4:0]             ex_rs1,
    output logic [4:0]             ex_rs2,
    output logic [4:0]             ex_rd,
    output logic [2:0]             ex_funct3,
    output logic [6:0]             ex_funct7,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] alu_op;
        logic       branch;
    } ctrl_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } fields_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    ctrl_t                   ctrl_q, ctrl_d, id_ctrl;
    fields_t                 fld_q, fld_d, id_fld;
    logic [STALL_CNT_W-1:0]  cnt_q, cnt_d;
    logic                    uses_rs1, uses_rs2;
    logic                    hazard, stall;

    assign id_ctrl = '{alu_src:    id_ALUSrc,
                       mem_to_reg: id_MemtoReg,
                       reg_write:  id_RegWrite,
                       mem_read:   id_MemRead,
                       mem_write:  id_MemWrite,
                       alu_op:     id_ALUOp,
                       branch:     id_Branch};

    assign id_fld = '{rs1:    id_rs1,
                      rs2:    id_rs2,
                      rd:     id_rd,
                      funct3: id_funct3,
                      funct7: id_funct7};

    // Only formats that really read a source register may stall; otherwise the
    // raw rs fields (immediate bits for I/U/J types) would raise false hazards.
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_Opcode)
            OP_RTYPE, OP_STORE, OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_ITYPE, OP_LOAD: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign hazard = ctrl_q.mem_read && (fld_q.rd != 5'd0) &&
                    ((uses_rs1 && (fld_q.rd == id_rs1)) ||
                     (uses_rs2 && (fld_q.rd == id_rs2)));
    assign stall      = hazard && !ex_flush;
    assign pc_write   = !stall;
    assign ifid_write = !stall;

    always_comb begin
        ctrl_d = id_ctrl;
        fld_d  = id_fld;
        cnt_d  = cnt_q;
        if (ex_flush) begin
            ctrl_d = '0;
            fld_d  = '0;
        end else if (stall) begin
            ctrl_d = '0;
            fld_d  = '0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + STALL_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= '0;
            fld_q  <= '0;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            fld_q  <= fld_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ex_ALUSrc   = ctrl_q.alu_src;
    assign ex_MemtoReg = ctrl_q.mem_to_reg;
    assign ex_RegWrite = ctrl_q.reg_write;
    assign ex_MemRead  = ctrl_q.mem_read;
    assign ex_MemWrite = ctrl_q.mem_write;
    assign ex_Branch   = ctrl_q.branch;
    assign ex_ALUOp    = ctrl_q.alu_op;
    assign ex_rs1      = fld_q.rs1;
    assign ex_rs2      = fld_q.rs2;
    assign ex_rd       = fld_q.rd;
    assign ex_funct3   = fld_q.funct3;
    assign ex_funct7   = fld_q.funct7;
    assign stall_count = cnt_q;

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
ID/EX pipeline stage placed directly downstream of the decode controller. Registers the controller's control bundle and the decoded register fields into EX. Detects load-use hazards and stalls PC and IF/ID while inserting a bubble. Squashes the ID/EX contents when EX resolves a taken branch.

Parameters:
STALL_CNT_W, 16, width of the saturating load-use stall counter.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
id_Opcode  in  7  opcode of the instruction in ID
id_ALUSrc  in  1  controller output
id_MemtoReg  in  1  controller output
id_RegWrite  in  1  controller output
id_MemRead  in  1  controller output
id_MemWrite  in  1  controller output
id_ALUOp  in  2  controller output
id_Branch  in  1  controller output
id_rs1, id_rs2, id_rd  in  5 each  register fields
id_funct3  in  3  funct3 field
id_funct7  in  7  funct7 field
ex_flush  in  1  taken branch resolved in EX this cycle
pc_write  out  1  PC load enable (combinational)
ifid_write  out  1  IF/ID load enable (combinational)
ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch  out  1 each  registered control
ex_ALUOp  out  2  registered ALUOp
ex_rs1, ex_rs2, ex_rd  out  5 each  registered fields
ex_funct3  out  3  registered funct3
ex_funct7  out  7  registered funct7
stall_count  out  STALL_CNT_W  number of load-use stall cycles, saturating

Behaviour:
- Reset: all ex_* outputs and stall_count go to 0 on the clock edge where reset=1. Reset has priority over every other input. pc_write and ifid_write are 1 during and after reset, because the registered ex_MemRead is 0.
- Operand use, decoded from id_Opcode:
  - uses_rs1 for 0110011, 0010011, 0000011, 0100011, 1100011.
  - uses_rs2 for 0110011, 0100011, 1100011.
  - Any other opcode uses neither register.
- hazard = ex_MemRead & (ex_rd != 0) & ((uses_rs1 & ex_rd == id_rs1) | (uses_rs2 & ex_rd == id_rs2)). Combinational, based on the current registered ex_* values.
- stall = hazard & ~ex_flush.
- pc_write = ifid_write = ~stall.
- Next-edge update, first matching rule wins:
  - ex_flush=1: all ex_* control bits and ex_ALUOp are cleared to 0. Field outputs (rs1, rs2, rd, funct3, funct7) are also cleared to 0. Flush overrides the hazard; stall_count is unchanged.
  - stall=1: bubble. Control bits and ex_ALUOp are cleared; field outputs are cleared. stall_count increments by 1, saturating at all-ones.
  - Otherwise: all id_* inputs are captured into the corresponding ex_* outputs. Latency is 1 cycle.
- A stall lasts exactly one cycle per load. After the bubble, ex_MemRead=0, so the hazard deasserts and the held ID instruction advances.
- Back-to-back loads, where the second depends on the first: one stall, then normal flow.
- rd=x0 never triggers a stall.
- Reset asserted mid-stall: outputs clear; no residual stall on the following cycle.

Test Plan:
- Reset: hold reset=1 for 2 cycles with arbitrary inputs -> all ex_* = 0, stall_count = 0, pc_write = ifid_write = 1.
- Pass-through: R-type (Opcode 0110011, RegWrite=1, ALUOp=10, rs1=3, rs2=4, rd=5) -> next cycle ex_RegWrite=1, ex_ALUOp=10, ex_rd=5, and no stall.
- Load-use: lw x5, then add with rs2=5 -> pc_write = ifid_write = 0 for one cycle, then ex_* all 0 (bubble) and stall_count=1. The next cycle the add is captured (ex_rs2=5).
- No false stall:
  - lw x0, then add with rs1=0 -> no stall.
  - lw x5, then I-type (Opcode 0010011) with rs2 field=5, rs1=1 -> no stall.
- Flush vs hazard: lw x5 in EX, sw using rs1=5 in ID, ex_flush=1 -> pc_write=1, ex_* cleared next cycle, stall_count unchanged.
- Saturation: STALL_CNT_W=2, force 5 load-use stalls -> stall_count reads 1, 2, 3, 3, 3.
